// File: rtl/regfile_pkg.sv
`default_nettype none
// ============================================================================
// Module      : regfile_pkg
// Description : Shared constants and helper functions for the register bank.
//               XLEN/NREGS give the default entry width and depth.
//               byte_merge selects one byte lane from new or old data.
//               addr_valid tells whether an address maps to a writable,
//               readable storage entry.
// Revision    : 1.0 - initial release
// ============================================================================
package regfile_pkg;

    localparam int XLEN  = 32;
    localparam int NREGS = 32;

    // One byte lane of a strobed write: strobe set takes the new byte.
    function automatic logic [7:0] byte_merge(
        input logic [7:0] old_byte,
        input logic [7:0] new_byte,
        input logic       strb
    );
        return strb ? new_byte : old_byte;
    endfunction

    // An address is backed by storage when it is below the depth and is
    // not the hard-wired zero entry.
    function automatic logic addr_valid(
        input logic [31:0] addr,
        input int unsigned depth,
        input logic        zero_reg0
    );
        return (addr < depth) && !(zero_reg0 && (addr == 32'd0));
    endfunction

endpackage
`default_nettype wire

// File: rtl/regfile_rd_port.sv
`default_nettype none
// ============================================================================
// Module      : regfile_rd_port
// Description : One combinational read port of the register bank. Selects
//               an entry from the flattened storage, returns 0 for the zero
//               entry or out-of-range addresses and, when BYPASS is set,
//               forwards the strobed bytes of a same-cycle write.
// Ports       : rst      - synchronous reset (suppresses bypass)
//               we       - write enable of the bank's write port
//               waddr    - write address
//               wdata    - write data
//               wstrb    - write byte strobes
//               raddr    - read address of this port
//               mem_flat - all entries, entry e at [e*WIDTH +: WIDTH]
//               rdata    - read data
// Revision    : 1.0 - initial release
// ============================================================================
module regfile_rd_port
    import regfile_pkg::*;
#(
    parameter int WIDTH     = XLEN,
    parameter int DEPTH     = NREGS,
    parameter int AW        = 5,
    parameter int ZERO_REG0 = 1,
    parameter int BYPASS    = 0
) (
    input  logic                   rst,
    input  logic                   we,
    input  logic [AW-1:0]          waddr,
    input  logic [WIDTH-1:0]       wdata,
    input  logic [WIDTH/8-1:0]     wstrb,
    input  logic [AW-1:0]          raddr,
    input  logic [DEPTH*WIDTH-1:0] mem_flat,
    output logic [WIDTH-1:0]       rdata
);

    localparam int c_NB = WIDTH / 8;

    logic [WIDTH-1:0] w_entry;
    logic [WIDTH-1:0] w_merged;
    logic             w_rd_ok;
    logic             w_hit;

    // Compare-based mux: addresses beyond DEPTH match nothing and read 0.
    always_comb begin
        w_entry = '0;
        for (int e = 0; e < DEPTH; e++) begin
            if (raddr == AW'(e)) begin
                w_entry = mem_flat[e*WIDTH +: WIDTH];
            end
        end
    end

    always_comb begin
        w_merged = '0;
        for (int k = 0; k < c_NB; k++) begin
            w_merged[8*k +: 8] = byte_merge(w_entry[8*k +: 8], wdata[8*k +: 8], wstrb[k]);
        end
    end

    assign w_rd_ok = addr_valid(32'(raddr), DEPTH, ZERO_REG0 != 0);

    // A valid write address equal to raddr implies raddr is valid too.
    assign w_hit = (BYPASS != 0) && !rst && we && (waddr == raddr)
                 && addr_valid(32'(waddr), DEPTH, ZERO_REG0 != 0);

    assign rdata = w_hit   ? w_merged :
                   w_rd_ok ? w_entry  : '0;

endmodule
`default_nettype wire

// File: rtl/regfile_bank.sv
`default_nettype none
// ============================================================================
// Module      : regfile_bank
// Description : Parametrised register bank with NUM_RD combinational read
//               ports and one synchronous byte-strobed write port. Entry 0
//               may be hard-wired to zero; write-to-read bypass optional.
// Ports       : clk   - clock, all state updates on the rising edge
//               rst   - synchronous active-high reset, loads RESET_VAL
//               we    - write enable
//               waddr - write address
//               wdata - write data
//               wstrb - byte strobes, bit k gates wdata[8k+7:8k]
//               raddr - packed read addresses, port i at [i*AW +: AW]
//               rdata - packed read data, port i at [i*WIDTH +: WIDTH]
// Revision    : 1.0 - initial release
// ============================================================================
module regfile_bank
    import regfile_pkg::*;
#(
    parameter int               WIDTH     = XLEN,
    parameter int               DEPTH     = NREGS,
    parameter int               NUM_RD    = 2,
    parameter int               ZERO_REG0 = 1,
    parameter int               BYPASS    = 0,
    parameter logic [WIDTH-1:0] RESET_VAL = '0,
    localparam int              AW        = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    we,
    input  logic [AW-1:0]           waddr,
    input  logic [WIDTH-1:0]        wdata,
    input  logic [WIDTH/8-1:0]      wstrb,
    input  logic [NUM_RD*AW-1:0]    raddr,
    output logic [NUM_RD*WIDTH-1:0] rdata
);

    localparam int c_NB = WIDTH / 8;

    generate
        if ((WIDTH % 8) != 0) begin : g_width_check
            $error("regfile_bank: WIDTH must be a multiple of 8");
        end
        if ((NUM_RD < 1) || (NUM_RD > 4)) begin : g_num_rd_check
            $error("regfile_bank: NUM_RD must be in 1..4");
        end
    endgenerate

    logic [WIDTH-1:0]       r_mem [DEPTH];
    logic [DEPTH*WIDTH-1:0] w_mem_flat;
    logic [WIDTH-1:0]       w_old;
    logic [WIDTH-1:0]       w_merged;
    logic                   w_wr_en;

    // Entry 0 (when hard-wired) and out-of-range targets are dropped here,
    // so nothing aliases onto a real entry.
    assign w_wr_en = we && addr_valid(32'(waddr), DEPTH, ZERO_REG0 != 0);

    always_comb begin
        w_old = '0;
        for (int e = 0; e < DEPTH; e++) begin
            if (waddr == AW'(e)) begin
                w_old = r_mem[e];
            end
        end
    end

    always_comb begin
        w_merged = '0;
        for (int k = 0; k < c_NB; k++) begin
            w_merged[8*k +: 8] = byte_merge(w_old[8*k +: 8], wdata[8*k +: 8], wstrb[k]);
        end
    end

    // Reset has priority over a write in the same cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int e = 0; e < DEPTH; e++) begin
                r_mem[e] <= RESET_VAL;
            end
        end else if (w_wr_en) begin
            for (int e = 0; e < DEPTH; e++) begin
                if (waddr == AW'(e)) begin
                    r_mem[e] <= w_merged;
                end
            end
        end
    end

    generate
        for (genvar e = 0; e < DEPTH; e++) begin : g_flat
            assign w_mem_flat[e*WIDTH +: WIDTH] = r_mem[e];
        end

        for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
            regfile_rd_port #(
                .WIDTH     (WIDTH),
                .DEPTH     (DEPTH),
                .AW        (AW),
                .ZERO_REG0 (ZERO_REG0),
                .BYPASS    (BYPASS)
            ) u_rd_port (
                .rst      (rst),
                .we       (we),
                .waddr    (waddr),
                .wdata    (wdata),
                .wstrb    (wstrb),
                .raddr    (raddr[i*AW +: AW]),
                .mem_flat (w_mem_flat),
                .rdata    (rdata[i*WIDTH +: WIDTH])
            );
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_regfile_bank.sv
`default_nettype none
// ============================================================================
// Module      : tb_regfile_bank
// Description : Self-checking bench for regfile_bank. Three instances:
//               A - defaults (zero entry 0, read-old),
//               B - entry 0 writable, write-first bypass,
//               C - 3 read ports, DEPTH 24.
//               Stimulus pushes expected read values into a queue; a monitor
//               on the falling edge pops and compares them.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_regfile_bank;

    localparam int c_A0 = 0, c_A1 = 1, c_B0 = 2, c_B1 = 3;
    localparam int c_C0 = 4, c_C1 = 5, c_C2 = 6;

    logic        clk = 1'b0;
    logic        r_rst;
    logic        r_we;
    logic [4:0]  r_waddr;
    logic [31:0] r_wdata;
    logic [3:0]  r_wstrb;
    logic [9:0]  r_raddr;
    logic [63:0] w_rdata_a;
    logic [63:0] w_rdata_b;

    logic        r_rst_c;
    logic        r_we_c;
    logic [4:0]  r_waddr_c;
    logic [31:0] r_wdata_c;
    logic [3:0]  r_wstrb_c;
    logic [14:0] r_raddr_c;
    logic [95:0] w_rdata_c;

    int checks = 0;
    int errors = 0;

    logic [31:0] exp_q  [$];
    int          sel_q  [$];
    string       name_q [$];

    always #5 clk = ~clk;

    regfile_bank #(.ZERO_REG0(1), .BYPASS(0)) u_a (
        .clk(clk), .rst(r_rst), .we(r_we), .waddr(r_waddr), .wdata(r_wdata),
        .wstrb(r_wstrb), .raddr(r_raddr), .rdata(w_rdata_a)
    );

    regfile_bank #(.ZERO_REG0(0), .BYPASS(1)) u_b (
        .clk(clk), .rst(r_rst), .we(r_we), .waddr(r_waddr), .wdata(r_wdata),
        .wstrb(r_wstrb), .raddr(r_raddr), .rdata(w_rdata_b)
    );

    regfile_bank #(.DEPTH(24), .NUM_RD(3)) u_c (
        .clk(clk), .rst(r_rst_c), .we(r_we_c), .waddr(r_waddr_c), .wdata(r_wdata_c),
        .wstrb(r_wstrb_c), .raddr(r_raddr_c), .rdata(w_rdata_c)
    );

    function automatic logic [31:0] get_out(input int sel);
        case (sel)
            c_A0:    return w_rdata_a[31:0];
            c_A1:    return w_rdata_a[63:32];
            c_B0:    return w_rdata_b[31:0];
            c_B1:    return w_rdata_b[63:32];
            c_C0:    return w_rdata_c[31:0];
            c_C1:    return w_rdata_c[63:32];
            c_C2:    return w_rdata_c[95:64];
            default: return 32'hxxxx_xxxx;
        endcase
    endfunction

    // Monitor: compares everything queued for this cycle, mid-cycle.
    always @(negedge clk) begin
        while (exp_q.size() != 0) begin
            logic [31:0] e;
            logic [31:0] act;
            int          s;
            string       n;
            e   = exp_q.pop_front();
            s   = sel_q.pop_front();
            n   = name_q.pop_front();
            act = get_out(s);
            checks++;
            if (act !== e) begin
                errors++;
                $display("FAIL %s (out %0d): got %h, required %h", n, s, act, e);
            end
        end
    end

    task automatic chk(input int sel, input logic [31:0] v, input string nm);
        exp_q.push_back(v);
        sel_q.push_back(sel);
        name_q.push_back(nm);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_wr(input logic w, input logic [4:0] a, input logic [31:0] d,
                          input logic [3:0] s);
        r_we    = w;
        r_waddr = a;
        r_wdata = d;
        r_wstrb = s;
    endtask

    task automatic set_rd(input logic [4:0] a0, input logic [4:0] a1);
        r_raddr = {a1, a0};
    endtask

    task automatic wr_c(input logic [4:0] a, input logic [31:0] d);
        r_we_c    = 1'b1;
        r_waddr_c = a;
        r_wdata_c = d;
        r_wstrb_c = 4'hF;
        tick();
        r_we_c    = 1'b0;
    endtask

    initial begin
        #1ms;
        $display("FAIL timeout: simulation still running, required finished");
        $fatal(1, "timeout");
    end

    initial begin
        int wait_cyc;
        r_rst = 1'b1; r_rst_c = 1'b1;
        set_wr(1'b0, 5'd0, 32'h0, 4'h0);
        set_rd(5'd0, 5'd0);
        r_we_c = 1'b0; r_waddr_c = '0; r_wdata_c = '0; r_wstrb_c = '0; r_raddr_c = '0;
        tick();
        tick();
        r_rst = 1'b0; r_rst_c = 1'b0;

        // 1: fill 1..31, then reset clears everything.
        for (int i = 1; i < 32; i++) begin
            set_wr(1'b1, 5'(i), 32'h1000_0000 + 32'(i), 4'hF);
            tick();
        end
        set_wr(1'b0, 5'd0, 32'h0, 4'h0);
        set_rd(5'd31, 5'd1);
        chk(c_A0, 32'h1000_001F, "fill_a0");
        chk(c_A1, 32'h1000_0001, "fill_a1");
        chk(c_B0, 32'h1000_001F, "fill_b0");
        chk(c_B1, 32'h1000_0001, "fill_b1");
        tick();
        r_rst = 1'b1;
        tick();
        r_rst = 1'b0;
        for (int i = 0; i < 32; i++) begin
            set_rd(5'(i), 5'(31 - i));
            chk(c_A0, 32'h0, "rst_a0");
            chk(c_A1, 32'h0, "rst_a1");
            chk(c_B0, 32'h0, "rst_b0");
            chk(c_B1, 32'h0, "rst_b1");
            tick();
        end

        // 2: write, hold, overwrite entry 5.
        set_rd(5'd5, 5'd0);
        set_wr(1'b1, 5'd5, 32'hA5A5_A5A5, 4'hF);
        chk(c_A0, 32'h0000_0000, "wr5_pre_a");
        chk(c_B0, 32'hA5A5_A5A5, "wr5_pre_b_bypass");
        tick();
        set_wr(1'b0, 5'd0, 32'h0, 4'h0);
        for (int i = 0; i < 3; i++) begin
            chk(c_A0, 32'hA5A5_A5A5, "hold5_a");
            chk(c_B0, 32'hA5A5_A5A5, "hold5_b");
            tick();
        end
        set_wr(1'b1, 5'd5, 32'h5A5A_5A5A, 4'hF);
        chk(c_A0, 32'hA5A5_A5A5, "ovr5_pre_a");
        chk(c_B0, 32'h5A5A_5A5A, "ovr5_pre_b");
        tick();
        set_wr(1'b0, 5'd0, 32'h0, 4'h0);
        chk(c_A0, 32'h5A5A_5A5A, "ovr5_a");
        chk(c_B0, 32'h5A5A_5A5A, "ovr5_b");
        tick();

        // 3: byte strobes on entry 7.
        set_rd(5'd7, 5'd5);
        set_wr(1'b1, 5'd7, 32'h1122_3344, 4'hF);
        chk(c_A0, 32'h0000_0000, "wr7_pre_a");
        chk(c_B0, 32'h1122_3344, "wr7_pre_b");
        tick();
        set_wr(1'b1, 5'd7, 32'hAABB_CCDD, 4'b0101);
        chk(c_A0, 32'h1122_3344, "strb_pre_a");
        chk(c_B0, 32'h11BB_33DD, "strb_pre_b_merge");
        chk(c_A1, 32'h5A5A_5A5A, "strb_other_a");
        tick();
        set_wr(1'b1, 5'd7, 32'hFFFF_FFFF, 4'h0);
        chk(c_A0, 32'h11BB_33DD, "strb_a");
        chk(c_B0, 32'h11BB_33DD, "strb0_pre_b");
        tick();
        set_wr(1'b0, 5'd0, 32'h0, 4'h0);
        chk(c_A0, 32'h11BB_33DD, "strb0_a");
        chk(c_B0, 32'h11BB_33DD, "strb0_b");
        tick();

        // 4: entry 0, hard-wired (A) versus ordinary (B).
        set_rd(5'd0, 5'd0);
        set_wr(1'b1, 5'd0, 32'hDEAD_BEEF, 4'hF);
        chk(c_A0, 32'h0, "zero_pre_a0");
        chk(c_A1, 32'h0, "zero_pre_a1");
        chk(c_B0, 32'hDEAD_BEEF, "zero_pre_b0");
        tick();
        set_wr(1'b0, 5'd0, 32'h0, 4'h0);
        chk(c_A0, 32'h0, "zero_a0");
        chk(c_A1, 32'h0, "zero_a1");
        chk(c_B0, 32'hDEAD_BEEF, "zero_b0");
        chk(c_B1, 32'hDEAD_BEEF, "zero_b1");
        tick();

        // 5: bypass on entry 9, then bypass suppressed under reset.
        set_rd(5'd9, 5'd9);
        set_wr(1'b1, 5'd9, 32'h5A5A_5A5A, 4'hF);
        chk(c_A0, 32'h0000_0000, "byp_pre_a");
        chk(c_B0, 32'h5A5A_5A5A, "byp_pre_b0");
        chk(c_B1, 32'h5A5A_5A5A, "byp_pre_b1");
        tick();
        set_wr(1'b0, 5'd0, 32'h0, 4'h0);
        chk(c_A0, 32'h5A5A_5A5A, "byp_post_a");
        chk(c_B0, 32'h5A5A_5A5A, "byp_post_b");
        tick();
        r_rst = 1'b1;
        set_wr(1'b1, 5'd9, 32'hFFFF_FFFF, 4'hF);
        chk(c_B0, 32'h5A5A_5A5A, "byp_rst_b");
        chk(c_A0, 32'h5A5A_5A5A, "rst_pre_a");
        tick();
        r_rst = 1'b0;
        set_wr(1'b0, 5'd0, 32'h0, 4'h0);
        chk(c_A0, 32'h0, "rst_wins_a");
        chk(c_B0, 32'h0, "rst_wins_b");
        tick();

        // 6: three ports, DEPTH 24.
        wr_c(5'd2, 32'h22);
        wr_c(5'd3, 32'h33);
        wr_c(5'd4, 32'h44);
        r_raddr_c = {5'd4, 5'd3, 5'd2};
        chk(c_C0, 32'h22, "c_rd2");
        chk(c_C1, 32'h33, "c_rd3");
        chk(c_C2, 32'h44, "c_rd4");
        tick();
        wr_c(5'd30, 32'hFFFF_FFFF);
        r_raddr_c = {5'd6, 5'd14, 5'd30};
        chk(c_C0, 32'h0, "c_oor30");
        chk(c_C1, 32'h0, "c_alias14");
        chk(c_C2, 32'h0, "c_alias6");
        tick();
        r_raddr_c = {5'd4, 5'd3, 5'd2};
        chk(c_C0, 32'h22, "c_keep2");
        chk(c_C1, 32'h33, "c_keep3");
        chk(c_C2, 32'h44, "c_keep4");
        tick();
        r_rst_c = 1'b1;
        r_we_c = 1'b1; r_waddr_c = 5'd3; r_wdata_c = 32'hFF; r_wstrb_c = 4'hF;
        tick();
        r_rst_c = 1'b0;
        r_we_c = 1'b0;
        chk(c_C0, 32'h0, "c_rst2");
        chk(c_C1, 32'h0, "c_rst3");
        chk(c_C2, 32'h0, "c_rst4");
        tick();

        wait_cyc = 0;
        while (exp_q.size() != 0 && wait_cyc < 20) begin
            @(negedge clk);
            wait_cyc++;
        end
        #1;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d checks pending, required 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
